mul_sequencer: RTL and testbench

Multi-cycle integer multiply sequencer for the DLX datapath. It accepts the decoder's `mul` qualifier (MULT/MULTU) with both operands and drives an iterative shift-add multiplier of radix 2^K. It holds the pipeline with `stall` until the 64-bit product is ready, then presents the result for exactly one cycle. It sits beside the ALU in the execute stage and is the only sequential owner of the multiplier resource.

---
 rtl/mul_sequencer.sv | 151 +++++++++++++++
 tb/tb_mul_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Iterative radix-2^K shift-add MULT/MULTU sequencer; MUL_EARLY_EXIT_EN ends RUN once the multiplier is exhausted.
// Latency 32/K+2 cycles from start; holds the pipeline via stall = start & ~done, flush squashes in flight.
module mul_sequencer #(
    parameter int K = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_unsigned,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        ovf
);

    localparam int N = 32 / K;
    localparam logic [5:0] LAST = 6'(N - 1);
    localparam logic [5:0] K_W  = 6'(K);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        uns_q, uns_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        ovf_q, ovf_d;

    logic [31:0] mag_a, mag_b;
    logic [31:0] mplier_shr;
    logic [63:0] pp;
    logic [63:0] fixed;
    logic [5:0]  shamt;
    logic        run_last;
    logic        ovf_fix;

    // Datapath: magnitudes in, unsigned partial products, sign restored in FIX.
    always_comb begin
        mag_a = (~is_unsigned & op_a[31]) ? (~op_a + 32'd1) : op_a;
        mag_b = (~is_unsigned & op_b[31]) ? (~op_b + 32'd1) : op_b;
        pp = '0;
        for (int i = 0; i < K; i++) begin
            if (mplier_q[i]) begin
                pp = pp + ({32'b0, mcand_q} << i);
            end
        end
        shamt      = cnt_q * K_W;
        mplier_shr = mplier_q >> K;
`ifdef MUL_EARLY_EXIT_EN
        run_last = (cnt_q == LAST) || (mplier_shr == '0);
`else
        run_last = (cnt_q == LAST);
`endif
        fixed   = neg_q ? (~acc_q + 64'd1) : acc_q;
        ovf_fix = uns_q ? (fixed[63:32] != '0) : (fixed[63:32] != {32{fixed[31]}});
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        uns_d    = uns_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start & ~flush) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    neg_d    = ~is_unsigned & (op_a[31] ^ op_b[31]);
                    uns_d    = is_unsigned;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_q + (pp << shamt);
                    mplier_d = mplier_shr;
                    cnt_d    = cnt_q + 6'd1;
                    if (run_last) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    res_lo_d = fixed[31:0];
                    res_hi_d = fixed[63:32];
                    ovf_d    = ovf_fix;
                    state_d  = DONE;
                end
            end
            // The result is already committed here, so flush is irrelevant.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            uns_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            uns_q    <= uns_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign stall     = start & ~done;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer with K=1, 2 and 4 instances side by side; reference products come from plain 64-bit arithmetic.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic        is_unsigned;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic [2:0]  busy_v, stall_v, done_v, ovf_v;
    logic [31:0] lo_v [3];
    logic [31:0] hi_v [3];

    int tests = 0;
    int fails = 0;
    int ks [3] = '{1, 2, 4};
    logic [31:0] last_lo [3];
    logic [31:0] last_hi [3];

    always #5 clk = ~clk;

    mul_sequencer #(.K(1)) u_k1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .is_unsigned(is_unsigned),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy_v[0]), .stall(stall_v[0]),
        .done(done_v[0]), .result_lo(lo_v[0]), .result_hi(hi_v[0]), .ovf(ovf_v[0]));
    mul_sequencer #(.K(2)) u_k2 (
        .clk(clk), .reset(reset), .start(start_v[1]), .is_unsigned(is_unsigned),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy_v[1]), .stall(stall_v[1]),
        .done(done_v[1]), .result_lo(lo_v[1]), .result_hi(hi_v[1]), .ovf(ovf_v[1]));
    mul_sequencer #(.K(4)) u_k4 (
        .clk(clk), .reset(reset), .start(start_v[2]), .is_unsigned(is_unsigned),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy_v[2]), .stall(stall_v[2]),
        .done(done_v[2]), .result_lo(lo_v[2]), .result_hi(hi_v[2]), .ovf(ovf_v[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycle of the done pulse, counted from the cycle start is first raised.
    function automatic int exp_latency(input int idx, input logic [31:0] b, input logic uns);
        int runs;
        logic [63:0] mag;
        mag  = (!uns && $signed(b) < 0) ? 64'(-longint'($signed(b))) : {32'b0, b};
        runs = 32 / ks[idx];
`ifdef MUL_EARLY_EXIT_EN
        runs = 1;
        while ((mag >> (runs * ks[idx])) != 0) runs++;
`endif
        return runs + 2;
    endfunction

    task automatic do_mul(input int idx, input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic [63:0] p;
        logic        ov;
        longint      sp;
        int          lat, cyc;
        bit          seen;
        if (uns) begin
            p  = {32'b0, a} * {32'b0, b};
            ov = (p > 64'h0000_0000_FFFF_FFFF);
        end else begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end
        lat = exp_latency(idx, b, uns);
        op_a = a;
        op_b = b;
        is_unsigned = uns;
        start_v[idx] = 1'b1;
        #1;
        chk("stall_c0", 64'(stall_v[idx]), 64'd1);
        chk("busy_c0", 64'(busy_v[idx]), 64'd0);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            if (done_v[idx]) seen = 1;
            else begin
                chk("stall_run", 64'(stall_v[idx]), 64'd1);
                chk("busy_run", 64'(busy_v[idx]), 64'd1);
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(cyc), 64'(lat));
        chk("stall_done", 64'(stall_v[idx]), 64'd0);
        chk("busy_done", 64'(busy_v[idx]), 64'd1);
        chk("result_lo", 64'(lo_v[idx]), 64'(p[31:0]));
        chk("result_hi", 64'(hi_v[idx]), 64'(p[63:32]));
        chk("ovf", 64'(ovf_v[idx]), 64'(ov));
        tick();
        start_v[idx] = 1'b0;
        chk("bubble_idle", 64'(busy_v[idx]), 64'd0);
        chk("done_once", 64'(done_v[idx]), 64'd0);
        chk("result_hold", {hi_v[idx], lo_v[idx]}, p);
        last_lo[idx] = p[31:0];
        last_hi[idx] = p[63:32];
    endtask

    initial begin
        bit          any_done;
        logic [31:0] ra, rb;
        reset = 1'b1;
        start_v = '0;
        is_unsigned = 1'b0;
        op_a = '0;
        op_b = '0;
        flush = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 64'(busy_v[i]), 64'd0);
            chk("rst_done", 64'(done_v[i]), 64'd0);
            chk("rst_stall", 64'(stall_v[i]), 64'd0);
            chk("rst_res", {31'b0, ovf_v[i], hi_v[i], lo_v[i]}, 64'd0);
        end
        #10 reset = 1'b0;
        tick();

        do_mul(0, 32'd7, 32'd6, 1'b1);
        do_mul(0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 3; i++) do_mul(i, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // flush in cycle 10 of a K=1 multiply, restart in cycle 12
        op_a = 32'd1234; op_b = 32'd99; is_unsigned = 1'b1;
        start_v[0] = 1'b1;
        any_done = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (done_v[0]) any_done = 1;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start_v[0] = 1'b0;
        chk("flush_idle", 64'(busy_v[0]), 64'd0);
        chk("flush_nodone", 64'(any_done | done_v[0]), 64'd0);
        chk("flush_keep", {hi_v[0], lo_v[0]}, {last_hi[0], last_lo[0]});
        tick();
        do_mul(0, 32'd2, 32'd3, 1'b1);

        // start together with flush in IDLE is ignored
        flush = 1'b1;
        start_v[0] = 1'b1;
        tick();
        chk("flush_start_ign", 64'(busy_v[0]), 64'd0);
        flush = 1'b0;
        start_v[0] = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 6; n++) begin
                ra = $urandom;
                rb = (n % 2 == 0) ? $urandom : ($urandom_range(0, 40) - 20);
                do_mul(i, ra, rb, 1'($urandom_range(0, 1)));
            end
        end
        do_mul(2, 32'd12345, 32'd0, 1'b0);
        do_mul(1, 32'hDEAD_BEEF, 32'd1, 1'b0);

        // asynchronous reset in the middle of RUN
        op_a = 32'd77; op_b = 32'd55; is_unsigned = 1'b1;
        start_v[0] = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy_v[0]), 64'd0);
        chk("arst_done", 64'(done_v[0]), 64'd0);
        chk("arst_res", {31'b0, ovf_v[0], hi_v[0], lo_v[0]}, 64'd0);
        chk("arst_stall", 64'(stall_v[0]), 64'd1);
        start_v[0] = 1'b0;
        #1 reset = 1'b0;
        any_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_v[0]) any_done = 1;
        end
        chk("arst_nodone", 64'(any_done), 64'd0);
        chk("arst_hold", {31'b0, ovf_v[0], hi_v[0], lo_v[0]}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
